axi2ahb_wctrl: RTL
==================

Name: axi2ahb_wctrl

Overview:
Write command/address stage of the AXI-to-AHB bridge, directly upstream of the write-data stage.
- Accepts one AXI AW command at a time and validates it.
- Generates the AHB address phase (HADDR/HTRANS/HSIZE/HWRITE/HBURST) per beat.
- Gates the write-data stage's per-beat handshake through the ctrl_wdata_* interface.
- Supplies the command ID and error flag that the data stage returns on B.

Parameters:
AXI_ID_WIDTH, 1, width of AWID / cmd_id_o
AXI_ADDR_WIDTH, 32, width of AWADDR / HADDR
AXI_DATA_WIDTH, 32, data bus width; legal values 32, 64, 128

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
AWID  in  AXI_ID_WIDTH  write command ID
AWADDR  in  AXI_ADDR_WIDTH  start address
AWLEN  in  8  beats minus one
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  command valid
AWREADY  out  1  command accepted
HADDR  out  AXI_ADDR_WIDTH  AHB address, registered
HTRANS  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ, registered
HSIZE  out  3  AHB size, registered
HBURST  out  3  fixed 3'b001 (INCR, undefined length)
HWRITE  out  1  1 whenever HTRANS != IDLE, registered
HREADY  in  1  AHB ready
cmd_id_o  out  AXI_ID_WIDTH  captured AWID, held until next AW accept
cmd_error_o  out  1  command/data error flag for the current command
ctrl_wdata_last_i  in  1  WLAST from the data stage
ctrl_wdata_valid_o  out  1  allows data stage to assert WREADY
ctrl_wdata_ready_i  in  1  WVALID from the data stage

Behaviour:
Reset and handshake:
- Reset: state IDLE; HADDR=0, HTRANS=00, HSIZE=0, HWRITE=0; cmd_id_o=0, cmd_error_o=0, counters 0.
- Reset mid-burst aborts the command immediately; no partial state survives.
- AWREADY = (state==IDLE). It is combinational and reads 1 after reset.
- AW handshake (AWVALID&&AWREADY) captures id, addr, len, size, burst; beat counter=AWLEN; first flag=1; state becomes ACTIVE.

Decode error:
- Set at capture if any of the following holds: AWSIZE > log2(AXI_DATA_WIDTH/8); AWBURST==11; WRAP with AWLEN not in {1,3,7,15}; AWADDR not aligned to AWSIZE.
- cmd_error_o is registered at capture and held for the whole command. It is also set (sticky) when ctrl_wdata_last_i disagrees with counter==0 on any beat.
- Cleared on the next AW accept.

ACTIVE state:
- ctrl_wdata_valid_o = HREADY.
- beat = ctrl_wdata_valid_o && ctrl_wdata_ready_i.

Registered AHB outputs, updated only when HREADY=1 (otherwise held):
- beat and no error: HADDR<=cur_addr, HSIZE<=size, HWRITE<=1.
  - HTRANS<=NONSEQ if first, FIXED burst, or cur_addr[9:0]==0 with not first (1KB boundary restart).
  - Otherwise HTRANS<=SEQ.
- beat with error: HTRANS<=IDLE, HWRITE<=0. Data is drained but no AHB transfer is issued.
- no beat, mid-burst (not first): HTRANS<=BUSY.
- no beat, otherwise: HTRANS<=IDLE.
- The address phase leads the data stage's 2-cycle HWDATA pipeline by one cycle, so beat N's data lands in its data phase.

Address update on each beat:
- INCR: cur_addr += 1<<size.
- FIXED: cur_addr unchanged.
- WRAP: the low bits within the window (len+1)<<size increment modulo the window; the upper bits are held.
- Arithmetic is AXI_ADDR_WIDTH bits; wrap past all-ones rolls over to 0.

Beat counter:
- Decrements on each beat and clears first.
- A beat with counter==0 ends the command: state becomes IDLE and HTRANS<=IDLE in the following HREADY cycle (unless a new command's first beat occurs).
- AWLEN=0 is a single NONSEQ.
- Early WLAST does not terminate the command; AWLEN governs.

Optional Feature:
Macro AXI2AHB_WCTRL_AW_SKID_EN.
- Defined: adds a one-entry AW holding register. AWREADY = holding register empty, so a command can be accepted while ACTIVE. On the final beat, the held command is loaded into the working registers in the same cycle. Its first beat may follow with no IDLE bubble; back-to-back bursts show NONSEQ directly after the last SEQ.
- Undefined: AWREADY only in IDLE; at least one IDLE cycle on HTRANS between commands.

Test Plan:
1. INCR len=3, size=2, addr 0x100, WVALID steady, HREADY=1 -> four ctrl_wdata_valid_o beats; HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x100,0x104,0x108,0x10C, each one cycle after its beat; HWRITE=1; cmd_error_o=0; AWREADY back to 1 after the last beat.
2. WRAP len=3, size=2, addr 0x108 -> HADDR 0x108,0x10C,0x100,0x104; INCR len=3, addr 0x3F8 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
3. INCR len=3 with WVALID low for 2 cycles after beat 1 -> HTRANS BUSY,BUSY, then SEQ resumes at 0x108; HREADY low for 3 cycles -> HADDR/HTRANS held and ctrl_wdata_valid_o=0.
4. AWSIZE=3 with AXI_DATA_WIDTH=32, len=1 -> cmd_error_o=1; two beats drained; HTRANS stays IDLE. Separately, WLAST on beat 0 of len=1 -> cmd_error_o=1 from the next cycle.
5. ARESETN low during beat 2 of len=7 -> all outputs at reset values asynchronously; after release, AWREADY=1 and a new len=0 command issues a single NONSEQ.
6. With AXI2AHB_WCTRL_AW_SKID_EN: two INCR len=1 commands presented back-to-back -> second AW accepted while ACTIVE; HTRANS NONSEQ,SEQ,NONSEQ,SEQ with no IDLE between. Without the macro -> one IDLE cycle between the bursts.

Source files
------------

// File: rtl/axi2ahb_wctrl.sv
// ---------------------------------------------------------------------------
// axi2ahb_wctrl -- write command/address stage of the AXI-to-AHB bridge.
//
// Accepts one AXI AW command, checks it for decode errors, and walks the
// burst address beat by beat. Each beat is released to the downstream
// write-data stage through ctrl_wdata_valid_o/ctrl_wdata_ready_i. The stage
// also drives the registered AHB address phase (one cycle after each beat).
// The command ID and error flag go to the data stage for the B response.
//
// Optional feature: define AXI2AHB_WCTRL_AW_SKID_EN to add a one-entry AW
// holding register. A second command can then be accepted while a burst is
// in flight, so back-to-back bursts run without an IDLE bubble.
//
// Ports:
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   AWID..AWVALID        AXI write command inputs
//   AWREADY              command accepted (combinational)
//   HADDR/HTRANS/HSIZE   registered AHB address phase
//   HBURST               constant INCR (undefined length)
//   HWRITE               registered, 1 whenever HTRANS != IDLE
//   HREADY               AHB ready
//   cmd_id_o             AWID of the current/last command
//   cmd_error_o          decode or WLAST error for the current command
//   ctrl_wdata_last_i    WLAST seen by the data stage
//   ctrl_wdata_valid_o   lets the data stage assert WREADY
//   ctrl_wdata_ready_i   WVALID from the data stage
// ---------------------------------------------------------------------------
module axi2ahb_wctrl #(
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [AXI_ID_WIDTH-1:0]   AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    output logic [AXI_ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]                HTRANS,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic                      HWRITE,
    input  logic                      HREADY,
    output logic [AXI_ID_WIDTH-1:0]   cmd_id_o,
    output logic                      cmd_error_o,
    input  logic                      ctrl_wdata_last_i,
    output logic                      ctrl_wdata_valid_o,
    input  logic                      ctrl_wdata_ready_i
);

    localparam int unsigned MaxSize = $clog2(AXI_DATA_WIDTH / 8);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                   state_q, state_d;
    addr_t                    addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               burst_q, burst_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     first_q, first_d;
    logic [AXI_ID_WIDTH-1:0]  id_q, id_d;
    logic                     err_q, err_d;

    addr_t                    haddr_q, haddr_d;
    logic [1:0]               htrans_q, htrans_d;
    logic [2:0]               hsize_q, hsize_d;
    logic                     hwrite_q, hwrite_d;

    // Command source for the working registers (AW port or holding register)
    logic                     ld;
    logic [AXI_ID_WIDTH-1:0]  ld_id;
    addr_t                    ld_addr;
    logic [7:0]               ld_len;
    logic [2:0]               ld_size;
    logic [1:0]               ld_burst;

    logic aw_hs;
    logic beat;
    logic last_beat;

    function automatic logic decode_err(input addr_t a, input logic [7:0] l,
                                        input logic [2:0] s, input logic [1:0] b);
        logic  e;
        addr_t amask;
        e     = 1'b0;
        amask = (addr_t'(1) << s) - addr_t'(1);
        if ({29'd0, s} > MaxSize) e = 1'b1;
        if (b == 2'b11) e = 1'b1;
        if (b == BurstWrap && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) e = 1'b1;
        if ((a & amask) != '0) e = 1'b1;
        return e;
    endfunction

    function automatic addr_t next_addr(input addr_t a, input logic [7:0] l,
                                        input logic [2:0] s, input logic [1:0] b);
        addr_t incr;
        addr_t wmask;
        incr  = addr_t'(1) << s;
        // Window is (len+1)<<size bytes; only the bits inside it advance.
        wmask = ((addr_t'(l) + addr_t'(1)) << s) - addr_t'(1);
        case (b)
            BurstFixed: next_addr = a;
            BurstWrap:  next_addr = (a & ~wmask) | ((a + incr) & wmask);
            default:    next_addr = a + incr;
        endcase
    endfunction

    assign ctrl_wdata_valid_o = (state_q == StActive) && HREADY;
    assign beat               = ctrl_wdata_valid_o && ctrl_wdata_ready_i;
    assign last_beat          = beat && (cnt_q == 8'd0);
    assign aw_hs              = AWVALID && AWREADY;

`ifdef AXI2AHB_WCTRL_AW_SKID_EN
    logic                     hold_valid_q, hold_valid_d;
    logic [AXI_ID_WIDTH-1:0]  hold_id_q, hold_id_d;
    addr_t                    hold_addr_q, hold_addr_d;
    logic [7:0]               hold_len_q, hold_len_d;
    logic [2:0]               hold_size_q, hold_size_d;
    logic [1:0]               hold_burst_q, hold_burst_d;

    assign AWREADY = !hold_valid_q;

    always_comb begin
        ld           = 1'b0;
        ld_id        = AWID;
        ld_addr      = AWADDR;
        ld_len       = AWLEN;
        ld_size      = AWSIZE;
        ld_burst     = AWBURST;
        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        hold_addr_d  = hold_addr_q;
        hold_len_d   = hold_len_q;
        hold_size_d  = hold_size_q;
        hold_burst_d = hold_burst_q;
        if (last_beat && hold_valid_q) begin
            // AWREADY is low here, so no new command competes for the slot
            ld           = 1'b1;
            ld_id        = hold_id_q;
            ld_addr      = hold_addr_q;
            ld_len       = hold_len_q;
            ld_size      = hold_size_q;
            ld_burst     = hold_burst_q;
            hold_valid_d = 1'b0;
        end else if (aw_hs && (state_q == StIdle || last_beat)) begin
            ld = 1'b1;
        end else if (aw_hs) begin
            hold_valid_d = 1'b1;
            hold_id_d    = AWID;
            hold_addr_d  = AWADDR;
            hold_len_d   = AWLEN;
            hold_size_d  = AWSIZE;
            hold_burst_d = AWBURST;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_valid_q <= 1'b0;
            hold_id_q    <= '0;
            hold_addr_q  <= '0;
            hold_len_q   <= '0;
            hold_size_q  <= '0;
            hold_burst_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            hold_addr_q  <= hold_addr_d;
            hold_len_q   <= hold_len_d;
            hold_size_q  <= hold_size_d;
            hold_burst_q <= hold_burst_d;
        end
    end
`else
    assign AWREADY = (state_q == StIdle);

    always_comb begin
        ld       = aw_hs;
        ld_id    = AWID;
        ld_addr  = AWADDR;
        ld_len   = AWLEN;
        ld_size  = AWSIZE;
        ld_burst = AWBURST;
    end
`endif

    // Command FSM and burst walker
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        id_d    = id_q;
        err_d   = err_q;
        if (beat) begin
            addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
            cnt_d   = cnt_q - 8'd1;
            first_d = 1'b0;
            if (ctrl_wdata_last_i != (cnt_q == 8'd0)) err_d = 1'b1;
            if (cnt_q == 8'd0) state_d = StIdle;
        end
        // A load on the final beat overrides the completed command
        if (ld) begin
            state_d = StActive;
            addr_d  = ld_addr;
            len_d   = ld_len;
            size_d  = ld_size;
            burst_d = ld_burst;
            cnt_d   = ld_len;
            first_d = 1'b1;
            id_d    = ld_id;
            err_d   = decode_err(ld_addr, ld_len, ld_size, ld_burst);
        end
    end

    // AHB address phase, advanced only while HREADY is high
    always_comb begin
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hsize_d  = hsize_q;
        hwrite_d = hwrite_q;
        if (HREADY) begin
            if (beat && !err_q) begin
                haddr_d  = addr_q;
                hsize_d  = size_q;
                hwrite_d = 1'b1;
                // Restart as NONSEQ at burst start, for FIXED, and at 1KB crossings
                if (first_q || burst_q == BurstFixed || addr_q[9:0] == 10'd0) begin
                    htrans_d = TransNonseq;
                end else begin
                    htrans_d = TransSeq;
                end
            end else if (beat) begin
                // Errored command: drain data without issuing transfers
                htrans_d = TransIdle;
                hwrite_d = 1'b0;
            end else if (state_q == StActive && !first_q && !err_q) begin
                htrans_d = TransBusy;
                hwrite_d = 1'b1;
            end else begin
                htrans_d = TransIdle;
                hwrite_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            id_q     <= '0;
            err_q    <= 1'b0;
            haddr_q  <= '0;
            htrans_q <= TransIdle;
            hsize_q  <= '0;
            hwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            id_q     <= id_d;
            err_q    <= err_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hsize_q  <= hsize_d;
            hwrite_q <= hwrite_d;
        end
    end

    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HSIZE       = hsize_q;
    assign HWRITE      = hwrite_q;
    assign HBURST      = 3'b001;
    assign cmd_id_o    = id_q;
    assign cmd_error_o = err_q;

endmodule
